// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the core ALU for
// one add or subtract per cycle, handing results back over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a request, ALU released to the core
// RUN   | one shift-add / restoring-divide step per cycle, ALU owned
// DONE  | result presented, held until the consumer takes it
module alu_muldiv_seq #(
   parameter int          WIDTH   = 32,
   parameter int          CNT_W   = 6,
   parameter logic [3:0]  ALU_ADD = 4'b0010,
   parameter logic [3:0]  ALU_SUB = 4'b0110
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             alu_own,
   output logic [WIDTH-1:0] alu_srca,
   output logic [WIDTH-1:0] alu_srcb,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   // acc holds hi (multiply) or rem (divide); sh holds lo or quot; opb holds mcand or dvsr
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]   opb_q, opb_d;

   logic [WIDTH-1:0]   mul_sum;
   logic               mul_carry;
   logic [WIDTH-1:0]   div_rs;
   logic               div_take;

   // Carry and borrow come from unsigned compares, so the ALU stays the only adder.
   assign mul_sum   = sh_q[0] ? alu_result : acc_q;
   assign mul_carry = sh_q[0] & (alu_result < acc_q);
   assign div_rs    = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
   assign div_take  = acc_q[WIDTH-1] | !(div_rs < opb_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      acc_d      = acc_q;
      sh_d       = sh_q;
      opb_d      = opb_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      alu_own    = 1'b0;
      alu_srca   = '0;
      alu_srcb   = '0;
      alu_ctrl   = ALU_ADD;

      if (!reset) begin
         case (state_q)
            S_IDLE: begin
               req_ready = 1'b1;
               if (req_valid) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  op_d    = req_op;
                  acc_d   = '0;
                  if (req_op[1]) begin
                     sh_d  = req_a;
                     opb_d = req_b;
                  end else begin
                     sh_d  = req_b;
                     opb_d = req_a;
                  end
               end
            end
            S_RUN: begin
               alu_own  = 1'b1;
               alu_srcb = opb_q;
               if (op_q[1]) begin
                  alu_srca = div_rs;
                  alu_ctrl = ALU_SUB;
                  acc_d    = div_take ? alu_result : div_rs;
                  sh_d     = {sh_q[WIDTH-2:0], div_take};
               end else begin
                  alu_srca = acc_q;
                  alu_ctrl = ALU_ADD;
                  acc_d    = {mul_carry, mul_sum[WIDTH-1:1]};
                  sh_d     = {mul_sum[0], sh_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               resp_valid = 1'b1;
               case (op_q)
                  2'b00:   resp_data = sh_q;
                  2'b01:   resp_data = acc_q;
                  2'b10:   resp_data = sh_q;
                  default: resp_data = acc_q;
               endcase
               if (resp_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         opb_q   <= opb_d;
      end
   end

endmodule
